// File: rtl/mem_burst_ctrl.sv
// Burst front-end for a single-port data memory: write bursts from a valid/ready source,
// read bursts through a 4-entry output FIFO. Define MEM_BURST_CTRL_RANGE_CHECK_EN to reject out-of-range bursts.
module mem_burst_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_srst_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  localparam int FIFO_DEPTH = 4;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W:0]      r_cnt;
  logic                r_wr_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_srst;
  logic                r_rd_req;
  logic                r_rd_req_last;
  logic                r_rd_pend;
  logic                r_rd_pend_last;
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic                r_fifo_last [FIFO_DEPTH];
  logic [1:0]          r_wr_ptr;
  logic [1:0]          r_rd_ptr;
  logic [2:0]          r_fifo_cnt;

  logic                w_cmd_fire;
  logic                w_reject;
  logic                w_wr_fire;
  logic                w_push;
  logic                w_pop;
  logic [1:0]          w_in_flight;
  logic [3:0]          w_occ;
  logic                w_issue;
  logic                w_last_beat;
  logic [ADDR_W-1:0]   w_addr_next;

  assign cmd_ready_o = arst_n_i & (r_state == IDLE);
  assign w_cmd_fire  = cmd_valid_i & cmd_ready_o;
  assign w_wr_fire   = wr_valid_i & r_wr_ready;
  assign w_push      = r_rd_pend;
  assign w_pop       = rd_valid_o & rd_ready_i;
  assign w_in_flight = {1'b0, r_rd_req} + {1'b0, r_rd_pend};
  // Credit check counts data already buffered plus data still in the memory pipeline.
  assign w_occ       = {1'b0, r_fifo_cnt} + {2'b00, w_in_flight} - {3'b000, w_pop};
  assign w_issue     = (r_state == READ) && (w_occ < 4'(FIFO_DEPTH));
  assign w_last_beat = (r_cnt == (LEN_W+1)'(1));
  assign w_addr_next = (r_addr == ADDR_W'(MEM_DEPTH-1)) ? '0 : r_addr + 1'b1;

`ifdef MEM_BURST_CTRL_RANGE_CHECK_EN
  logic              r_err;
  logic [ADDR_W:0]   w_end;
  assign w_end    = {1'b0, cmd_addr_i} + (ADDR_W+1)'(cmd_len_i);
  assign w_reject = w_cmd_fire && (w_end >= (ADDR_W+1)'(MEM_DEPTH));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_err <= 1'b0;
    else           r_err <= w_reject;
  end
  assign err_o = r_err;
`else
  assign w_reject = 1'b0;
  assign err_o    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_cnt         <= '0;
      r_wr_ready    <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_srst    <= 1'b1;
      r_rd_req      <= 1'b0;
      r_rd_req_last <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in the same block overrides them.
      r_mem_we      <= 1'b0;
      r_rd_req      <= 1'b0;
      r_rd_req_last <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cmd_fire && !w_reject) begin
            r_addr     <= cmd_addr_i;
            r_cnt      <= {1'b0, cmd_len_i} + (LEN_W+1)'(1);
            r_mem_srst <= 1'b0;
            if (cmd_write_i) begin
              r_state    <= WRITE;
              r_wr_ready <= 1'b1;
            end else begin
              r_state    <= READ;
            end
          end
        end
        WRITE: begin
          if (w_wr_fire) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= wr_data_i;
            r_addr      <= w_addr_next;
            r_cnt       <= r_cnt - 1'b1;
            if (w_last_beat) begin
              r_state    <= IDLE;
              r_wr_ready <= 1'b0;
              r_mem_srst <= 1'b1;
            end
          end
        end
        READ: begin
          if (w_issue) begin
            r_mem_addr    <= r_addr;
            r_rd_req      <= 1'b1;
            r_rd_req_last <= w_last_beat;
            r_addr        <= w_addr_next;
            r_cnt         <= r_cnt - 1'b1;
            if (w_last_beat) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!r_rd_req && !r_rd_pend && (r_fifo_cnt == 3'd0)) begin
            r_state    <= IDLE;
            r_mem_srst <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Second pipeline stage: the memory presents the requested word during this cycle.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_rd_pend      <= 1'b0;
      r_rd_pend_last <= 1'b0;
    end else begin
      r_rd_pend      <= r_rd_req;
      r_rd_pend_last <= r_rd_req_last;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      // NOTE: the four FIFO entries are reset so rd_data_o/rd_last_o read as zero out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= mem_rdata_i;
        r_fifo_last[r_wr_ptr] <= r_rd_pend_last;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  assign rd_valid_o  = (r_fifo_cnt != 3'd0);
  assign rd_data_o   = r_fifo_data[r_rd_ptr];
  assign rd_last_o   = r_fifo_last[r_rd_ptr];
  assign wr_ready_o  = r_wr_ready;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_srst_o  = r_mem_srst;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl with a 1024x32 registered-read memory model.
module tb_mem_burst_ctrl;

  logic        clk_i;
  logic        arst_n_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [15:0] cmd_addr_i;
  logic [7:0]  cmd_len_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [31:0] wr_data_i;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [31:0] rd_data_o;
  logic        rd_last_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_srst_o;
  logic [31:0] mem_rdata;
  logic        busy_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_burst_ctrl dut (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_write_i (cmd_write_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_data_i   (wr_data_i),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i),
    .rd_data_o   (rd_data_o),
    .rd_last_o   (rd_last_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_srst_o  (mem_srst_o),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Memory model: write on we, registered read data, srst clears only the read register.
  logic [31:0] mem [1024];
  always @(posedge clk_i) begin
    if (mem_we_o) mem[mem_addr_o[9:0]] <= mem_wdata_o;
    if (mem_srst_o)     mem_rdata <= '0;
    else if (!mem_we_o) mem_rdata <= mem[mem_addr_o[9:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'(arst_n_i));
    check({tag, "_wr_ready"},  32'(wr_ready_o),  32'd0);
    check({tag, "_rd_valid"},  32'(rd_valid_o),  32'd0);
    check({tag, "_rd_data"},   rd_data_o,        32'd0);
    check({tag, "_mem_we"},    32'(mem_we_o),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr_o),  32'd0);
    check({tag, "_mem_wdata"}, mem_wdata_o,      32'd0);
    check({tag, "_mem_srst"},  32'(mem_srst_o),  32'd1);
    check({tag, "_busy"},      32'(busy_o),      32'd0);
    check({tag, "_err"},       32'(err_o),       32'd0);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [31:0] base);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = addr; cmd_len_i = len;
    check("wr_cmd_ready", 32'(cmd_ready_o), 32'd1);
    step();
    cmd_valid_i = 1'b0;
    check("wr_no_err", 32'(err_o), 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      wr_valid_i = 1'b1; wr_data_i = base + 32'(i);
      step();
      check("wr_beat_we",   32'(mem_we_o),   32'd1);
      check("wr_beat_addr", 32'(mem_addr_o), 32'((addr + 16'(i)) & 16'h03FF));
      check("wr_beat_data", mem_wdata_o,     base + 32'(i));
    end
    wr_valid_i = 1'b0;
    check("wr_back_to_idle", 32'(cmd_ready_o), 32'd1);
  endtask

  task automatic read_burst(input logic [15:0] addr, input logic [7:0] len, input logic [31:0] base,
                            input int stall, input bit toggle);
    int k;
    int n;
    logic [9:0] issued;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = addr; cmd_len_i = len;
    rd_ready_i  = (stall == 0);
    check("rd_cmd_ready", 32'(cmd_ready_o), 32'd1);
    step();
    cmd_valid_i = 1'b0;
    k = 0;
    n = 0;
    while (k <= int'(len) && n < 400) begin
      if (n < stall)   rd_ready_i = 1'b0;
      else if (toggle) rd_ready_i = n[0];
      else             rd_ready_i = 1'b1;
      if (n >= 1) begin
        issued = 10'(mem_addr_o - addr) + 10'd1;
        check("rd_occupancy_le4", 32'(int'(issued) - k <= 4), 32'd1);
      end
      if (stall > 0 && n == stall - 1)
        check("rd_stall_issue_addr", 32'(mem_addr_o), 32'(addr + 16'd3));
      if (n < stall && rd_valid_o) begin
        check("rd_stall_hold_data", rd_data_o, base);
        check("rd_stall_hold_last", 32'(rd_last_o), 32'(len == 8'd0));
      end
      if (rd_valid_o && rd_ready_i) begin
        if (k == 0 && stall == 0) check("rd_first_latency", 32'(n), 32'd3);
        check("rd_data", rd_data_o, base + 32'(k));
        check("rd_last", 32'(rd_last_o), 32'(k == int'(len)));
        k++;
      end
      step();
      n++;
    end
    rd_ready_i = 1'b1;
    check("rd_beat_count", 32'(k), 32'(int'(len) + 1));
    n = 0;
    while (!cmd_ready_o && n < 50) begin
      step();
      n++;
    end
    check("rd_back_to_idle", 32'(cmd_ready_o), 32'd1);
    check("rd_fifo_empty",   32'(rd_valid_o),  32'd0);
  endtask

  typedef struct {
    logic        cmd_valid;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        e_cmd_ready;
    logic        e_wr_ready;
    logic        e_we;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_busy;
    logic        e_srst;
  } vec_t;

  vec_t vecs[8];
  int   k;
  int   n;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    arst_n_i = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    wr_valid_i = 1'b0; wr_data_i = '0; rd_ready_i = 1'b0;

    // Write burst 0x010, len 3, with a two-cycle gap in wr_valid_i.
    vecs[0] = '{1'b1, 1'b1, 16'h010, 8'd3, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 16'h000, 32'h00, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'h000, 8'd0, 1'b1, 32'hA0,    1'b0, 1'b1, 1'b1, 16'h010, 32'hA0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'h000, 8'd0, 1'b1, 32'hA1,    1'b0, 1'b1, 1'b1, 16'h011, 32'hA1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'h000, 8'd0, 1'b0, 32'hDEAD,  1'b0, 1'b1, 1'b0, 16'h011, 32'hA1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'h000, 8'd0, 1'b0, 32'hDEAD,  1'b0, 1'b1, 1'b0, 16'h011, 32'hA1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 16'h000, 8'd0, 1'b1, 32'hA2,    1'b0, 1'b1, 1'b1, 16'h012, 32'hA2, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 16'h000, 8'd0, 1'b1, 32'hA3,    1'b1, 1'b0, 1'b1, 16'h013, 32'hA3, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 16'h000, 8'd0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 16'h013, 32'hA3, 1'b0, 1'b1};

    repeat (2) step();
    check_reset_outputs("in_reset");
    arst_n_i = 1'b1;
    step();
    check_reset_outputs("after_reset");

    for (int i = 0; i < 8; i++) begin
      cmd_valid_i = vecs[i].cmd_valid; cmd_write_i = vecs[i].cmd_write;
      cmd_addr_i  = vecs[i].cmd_addr;  cmd_len_i   = vecs[i].cmd_len;
      wr_valid_i  = vecs[i].wr_valid;  wr_data_i   = vecs[i].wr_data;
      step();
      check($sformatf("vec%0d_cmd_ready", i), 32'(cmd_ready_o), 32'(vecs[i].e_cmd_ready));
      check($sformatf("vec%0d_wr_ready", i),  32'(wr_ready_o),  32'(vecs[i].e_wr_ready));
      check($sformatf("vec%0d_mem_we", i),    32'(mem_we_o),    32'(vecs[i].e_we));
      check($sformatf("vec%0d_mem_addr", i),  32'(mem_addr_o),  32'(vecs[i].e_addr));
      check($sformatf("vec%0d_mem_wdata", i), mem_wdata_o,      vecs[i].e_wdata);
      check($sformatf("vec%0d_busy", i),      32'(busy_o),      32'(vecs[i].e_busy));
      check($sformatf("vec%0d_mem_srst", i),  32'(mem_srst_o),  32'(vecs[i].e_srst));
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("mem_word_%0d", i), mem[10'h010 + 10'(i)], 32'hA0 + 32'(i));

    read_burst(16'h010, 8'd3, 32'hA0, 0, 1'b0);

    do_write(16'h100, 8'd15, 32'h5500);
    read_burst(16'h100, 8'd15, 32'h5500, 10, 1'b1);

`ifdef MEM_BURST_CTRL_RANGE_CHECK_EN
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 16'h3FE; cmd_len_i = 8'd3;
    step();
    cmd_valid_i = 1'b0; wr_valid_i = 1'b1; wr_data_i = 32'hBAD0;
    check("range_err_pulse", 32'(err_o),       32'd1);
    check("range_stay_idle", 32'(busy_o),      32'd0);
    check("range_cmd_ready", 32'(cmd_ready_o), 32'd1);
    step();
    check("range_err_one_cycle", 32'(err_o), 32'd0);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0;
    step();
    cmd_valid_i = 1'b0;
    check("range_rd_err_pulse", 32'(err_o), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("range_no_we",       32'(mem_we_o),   32'd0);
      check("range_no_wr_ready", 32'(wr_ready_o), 32'd0);
      check("range_no_rd_valid", 32'(rd_valid_o), 32'd0);
      check("range_no_err",      32'(err_o),      32'd0);
    end
    wr_valid_i = 1'b0;
`else
    do_write(16'h3FE, 8'd3, 32'hB0);
    read_burst(16'h3FE, 8'd3, 32'hB0, 0, 1'b0);
`endif

    // Reset in the middle of a read burst after two beats have been taken.
    do_write(16'h200, 8'd7, 32'h7700);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 16'h200; cmd_len_i = 8'd7; rd_ready_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    k = 0;
    n = 0;
    while (k < 2 && n < 50) begin
      if (rd_valid_o) begin
        check("mid_rd_data", rd_data_o, 32'h7700 + 32'(k));
        k++;
      end
      step();
      n++;
    end
    check("mid_two_beats", 32'(k), 32'd2);
    check("mid_still_busy", 32'(busy_o), 32'd1);
    #2 arst_n_i = 1'b0;
    #1 check_reset_outputs("mid_reset");
    step();
    arst_n_i = 1'b1;
    step();
    check_reset_outputs("mid_release");
    read_burst(16'h205, 8'd0, 32'h7705, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Burst front-end placed directly upstream of the single-port 1024×32 data memory. Accepts one command at a time (read or write burst: start address and beat count) and streams write data from a valid/ready source into memory. Streams read data from memory to a valid/ready sink through an internal 4-entry output FIFO, so sink backpressure never loses data. Drives the memory's `we_i`, `addr_i`, `wdata_i` and `srst_i`, and consumes its `rdata_o`, which the memory updates one cycle after a read request.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 32, data word width
- LEN_W, 8, burst length field width
- MEM_DEPTH, 1024, number of memory words
- clk_i  in  1  clock
- arst_n_i  in  1  reset; asynchronous, active-low
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_write_i  in  1  1 = write burst, 0 = read burst
- cmd_addr_i  in  ADDR_W  start word address
- cmd_len_i  in  LEN_W  beats minus one (0 = 1 beat, 255 = 256 beats)
- wr_valid_i / wr_ready_o  in/out  1  write-data handshake
- wr_data_i  in  DATA_W  write beat
- rd_valid_o / rd_ready_i  out/in  1  read-data handshake
- rd_data_o  out  DATA_W  read beat
- rd_last_o  out  1  final beat of the burst, qualified by rd_valid_o
- mem_we_o, mem_addr_o[ADDR_W], mem_wdata_o[DATA_W], mem_srst_o  out  memory request; all registered
- mem_rdata_i  in  DATA_W  memory read data
- busy_o  out  1  state ≠ IDLE
- err_o  out  1  one-cycle pulse on a rejected command

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- cmd_ready_o = (state == IDLE). A command is accepted when cmd_valid_i and cmd_ready_o are both high.
  - Latches the address and sets the beat counter to cmd_len_i+1.
  - Goes to WRITE or READ.
- WRITE:
  - wr_ready_o = 1.
  - On each wr handshake, the next cycle registers mem_we_o=1, mem_addr_o=addr, mem_wdata_o=wr_data_i. Then addr+1 and counter−1.
  - Without a handshake, mem_we_o=0.
  - After the last beat handshake, go to IDLE.
- READ:
  - Issues one read per cycle (mem_we_o=0, mem_addr_o=addr) while (fifo_count + in_flight − pop_this_cycle) < 4.
  - Each issued read is captured from mem_rdata_i two cycles after the issue decision: one cycle for the registered request, one for memory latency.
  - After the last issue, go to DRAIN.
- DRAIN: wait for in_flight==0 and FIFO empty, then go to IDLE.
- rd_last_o marks the beat whose index equals cmd_len_i.
- mem_srst_o = 1 in IDLE, 0 otherwise.
- The address counter is ADDR_W bits. The beat counter is LEN_W+1 bits.
- A simultaneous FIFO push and pop leaves fifo_count unchanged.

## Timing
- Reset values:
  - state IDLE, FIFO empty, in_flight 0.
  - cmd_ready_o 1 after reset release; 0 while arst_n_i is low.
  - rd_valid_o, wr_ready_o, mem_we_o, busy_o, err_o: 0.
  - mem_srst_o 1; mem_addr_o, mem_wdata_o, rd_data_o: 0.
- Reset mid-burst:
  - Immediately aborts the burst, discards the FIFO and in-flight reads, and drops mem_we_o.
  - The memory contents already written remain.
- Read latency: first rd_valid_o 3 cycles after command acceptance (issue, memory, FIFO). Sustains 1 beat/cycle while rd_ready_i stays high.
- rd_valid_o/rd_data_o/rd_last_o stay stable while rd_valid_o=1 and rd_ready_i=0.
- Write throughput: 1 beat/cycle. Gaps in wr_valid_i produce mem_we_o=0 cycles.
- The next command can be accepted in the cycle after the return to IDLE.

## Configuration
- MEM_BURST_CTRL_RANGE_CHECK_EN defined:
  - A command with cmd_addr_i + cmd_len_i ≥ MEM_DEPTH is accepted but rejected.
  - err_o pulses the cycle after acceptance and the state stays IDLE.
  - No memory requests, no wr_ready_o, no read beats.
- Undefined:
  - No check; err_o is tied to 0.
  - The address wraps from MEM_DEPTH−1 to 0.

## Test plan
- Write burst, addr 0x010, len 3, data 0xA0..0xA3 with a 2-cycle wr_valid_i gap -> mem writes 0x010..0x013 in order; one mem_we_o=0 gap per idle cycle; cmd_ready_o high again after the 4th beat.
- Read burst, addr 0x010, len 3, rd_ready_i=1 -> rd_data_o 0xA0,0xA1,0xA2,0xA3 on consecutive cycles starting 3 cycles after acceptance; rd_last_o only with 0xA3.
- Read burst, len 15, rd_ready_i low 10 cycles then toggling -> never more than 4 buffered+in-flight; all 16 beats in order, no loss or duplication.
- Addr 0x3FE, len 3 -> with macro: err_o 1-cycle pulse, no mem_we_o, no rd_valid_o. Without macro: addresses 0x3FE, 0x3FF, 0x000, 0x001.
- arst_n_i pulsed low mid read burst (after 2 beats) -> all outputs at reset values immediately, FIFO empty; a following 1-beat read (len 0) returns correct data with rd_last_o=1.
